div_issue_queue: RTL and testbench
==================================

DIV_ISSUE_QUEUE -- requirements
Module: div_issue_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, giving the number of request FIFO entries; the value SHALL be a power of 2 and at least 2.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  queue can accept a request.
REQ-007 in_dividend, in_divisor  input  WIDTH each  request operands.
REQ-008 div_dividend, div_divisor  output  WIDTH each  FIFO-head operands driven to the downstream combinational divider.
REQ-009 div_quotient, div_remainder  input  WIDTH each  combinational divider results for the current div_* operands.
REQ-010 out_valid  output  1  result register holds a result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_quotient, out_remainder  output  WIDTH each  registered result.
REQ-013 out_dbz  output  1  the registered result came from a divisor of 0.

Function
REQ-014 Handshakes SHALL follow these rules: a push occurs when in_valid && in_ready, and a result transfer occurs when out_valid && out_ready.
REQ-015 in_ready SHALL equal (count < DEPTH) and SHALL NOT depend on same-cycle pops; when the FIFO is full, in_ready SHALL be 0.
REQ-016 The FIFO SHALL use wrap-around read/write pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits.
REQ-017 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-018 div_dividend/div_divisor SHALL be driven from the FIFO head, and SHALL be all-zero when the FIFO is empty.
REQ-019 A pop (load) SHALL occur when count > 0 && (!out_valid || out_ready).
REQ-020 On a load with a nonzero head divisor, the block SHALL register out_quotient = div_quotient, out_remainder = div_remainder, out_dbz = 0.
REQ-021 On a load with a zero head divisor, the block SHALL register out_quotient = all-ones, out_remainder = head dividend, out_dbz = 1, ignoring the div_* inputs.
REQ-022 On every load, out_valid SHALL be 1 on the next cycle.
REQ-023 After a transfer with no load in the same cycle, out_valid SHALL be 0 on the next cycle.
REQ-024 The out_* data outputs SHALL hold stable while out_valid && !out_ready.
REQ-025 Minimum latency SHALL be 2 cycles: a push at edge N gives out_valid high after edge N+1.
REQ-026 Sustained throughput SHALL be one result per cycle when out_ready is held at 1.
REQ-027 Results SHALL leave in push order, with no drops and no duplicates.

Reset
REQ-028 While rst_n = 0, the block SHALL hold pointers, count, out_valid, out_quotient, out_remainder, out_dbz (and err_count when enabled) at 0; in_ready SHALL be 1.
REQ-029 Reset assertion mid-operation SHALL discard all queued and registered requests immediately, without waiting for a clock edge.
REQ-030 Reset deassertion SHALL be taken synchronously to clk, and the first push SHALL be accepted on the first edge after release.

Configuration
REQ-031 The macro DIV_ISSUE_DBZ_CNT_EN SHALL control the divide-by-zero counter feature.
REQ-032 With DIV_ISSUE_DBZ_CNT_EN defined, the block SHALL add output err_count (16 bits), incremented by 1 on each load with out_dbz result, saturating at 16'hFFFF.
REQ-033 Without DIV_ISSUE_DBZ_CNT_EN, the err_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 The bench SHALL cover this scenario: WIDTH=8, push 100/7 with out_ready=1 -> two cycles later out_valid=1, out_quotient=14, out_remainder=2, out_dbz=0.
REQ-035 The bench SHALL cover this scenario: push 55/0 -> out_quotient=8'hFF, out_remainder=55, out_dbz=1; with macro defined, err_count goes 0->1.
REQ-036 The bench SHALL cover this scenario: out_ready=0, push 5 requests back-to-back with DEPTH=4 -> in_ready=0 after the 5th accept (4 in the FIFO plus 1 in the result register); the 6th is held; out_* stable; then releasing out_ready yields all 5 results in order, one per cycle.
REQ-037 The bench SHALL cover this scenario: FIFO at count=2 with simultaneous push and pop for 10 cycles -> count stays 2, pointers wrap past DEPTH-1 to 0, order is preserved.
REQ-038 The bench SHALL cover this scenario: assert rst_n=0 mid-burst between clock edges -> out_valid=0 and in_ready=1 immediately; after release, a push of 9/3 yields quotient 3, remainder 0.
REQ-039 The bench SHALL cover this scenario: with macro defined, force the counter to 16'hFFFE and issue 3 divide-by-zero requests -> err_count ends at 16'hFFFF.

Source files
------------

// File: rtl/div_issue_queue.sv
// div_issue_queue: request FIFO feeding a combinational divider, with a registered result stage.
// Define DIV_ISSUE_DBZ_CNT_EN to add the saturating divide-by-zero counter output err_count.
`default_nettype none

module div_issue_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
`ifdef DIV_ISSUE_DBZ_CNT_EN
  output logic [15:0]      err_count,
`endif
  output logic             out_dbz
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] mem_dvd_q [DEPTH];
  logic [WIDTH-1:0] mem_dvs_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_quo_q, out_quo_d;
  logic [WIDTH-1:0] out_rem_q, out_rem_d;
  logic             out_dbz_q, out_dbz_d;

  logic push, load, fifo_empty, head_dbz;

  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q < CNT_FULL);
  assign push       = in_valid && in_ready;
  // The result register can take a new head whenever it is empty or being drained this cycle.
  assign load       = !fifo_empty && (!out_valid_q || out_ready);

  assign div_dividend = fifo_empty ? '0 : mem_dvd_q[rd_ptr_q];
  assign div_divisor  = fifo_empty ? '0 : mem_dvs_q[rd_ptr_q];
  assign head_dbz     = (div_divisor == '0);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_quo_d   = out_quo_q;
    out_rem_d   = out_rem_q;
    out_dbz_d   = out_dbz_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (load) rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, load})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      if (head_dbz) begin
        out_quo_d = '1;
        out_rem_d = div_dividend;
        out_dbz_d = 1'b1;
      end else begin
        out_quo_d = div_quotient;
        out_rem_d = div_remainder;
        out_dbz_d = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_dvd_q[wr_ptr_q] <= in_dividend;
      mem_dvs_q[wr_ptr_q] <= in_divisor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_quo_q   <= '0;
      out_rem_q   <= '0;
      out_dbz_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_quo_q   <= out_quo_d;
      out_rem_q   <= out_rem_d;
      out_dbz_q   <= out_dbz_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_quotient  = out_quo_q;
  assign out_remainder = out_rem_q;
  assign out_dbz       = out_dbz_q;

`ifdef DIV_ISSUE_DBZ_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (load && head_dbz && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 16'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_issue_queue.sv
// Scoreboard bench for div_issue_queue: directed requests, a reference divider, and a result monitor.
`default_nettype none

module tb_div_issue_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_dividend, in_divisor;
  logic [7:0] div_dividend, div_divisor;
  logic [7:0] div_quotient, div_remainder;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_quotient, out_remainder;
  logic       out_dbz;
`ifdef DIV_ISSUE_DBZ_CNT_EN
  logic [15:0] err_count;
`endif

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  div_issue_queue #(.WIDTH(8), .DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
`ifdef DIV_ISSUE_DBZ_CNT_EN
    .err_count     (err_count),
`endif
    .out_dbz       (out_dbz)
  );

  // Reference divider; a zero divisor yields junk the DUT must ignore.
  always_comb begin
    if (div_divisor != 8'd0) begin
      div_quotient  = div_dividend / div_divisor;
      div_remainder = div_dividend % div_divisor;
    end else begin
      div_quotient  = 8'h5A;
      div_remainder = 8'hA5;
    end
  end

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 8'd0) e = '{q: 8'hFF, r: a, dbz: 1'b1};
    else           e = '{q: a / b, r: a % b, dbz: 1'b0};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each transferred result against the scoreboard, and checks hold stability.
  logic       prev_hold = 1'b0;
  logic [7:0] hold_q, hold_r;
  logic       hold_dbz;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_q", {24'd0, out_quotient}, {24'd0, hold_q});
        chk("hold_r", {24'd0, out_remainder}, {24'd0, hold_r});
        chk("hold_dbz", {31'd0, out_dbz}, {31'd0, hold_dbz});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got q=%0d r=%0d with empty scoreboard", out_quotient, out_remainder);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_quotient", {24'd0, out_quotient}, {24'd0, e.q});
          chk("out_remainder", {24'd0, out_remainder}, {24'd0, e.r});
          chk("out_dbz", {31'd0, out_dbz}, {31'd0, e.dbz});
        end
      end
      prev_hold = out_valid && !out_ready;
      hold_q    = out_quotient;
      hold_r    = out_remainder;
      hold_dbz  = out_dbz;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Present a request until accepted (bounded), recording its expected result on acceptance.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input exp_t e);
    bit acc = 0;
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, sb.size(), 32'd0);
  endtask

  logic [7:0] ta[5] = '{8'd200, 8'd17, 8'd63, 8'd0, 8'd250};
  logic [7:0] tb[5] = '{8'd9,   8'd4,  8'd0,  8'd5, 8'd3};

  initial begin
    bit acc6;
    logic [7:0] a, b;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_dividend = 8'd0;
    in_divisor  = 8'd0;
    out_ready   = 1'b1;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_q", {24'd0, out_quotient}, 32'd0);
    chk("rst_out_r", {24'd0, out_remainder}, 32'd0);
    chk("rst_out_dbz", {31'd0, out_dbz}, 32'd0);
    chk("rst_div_dividend", {24'd0, div_dividend}, 32'd0);
`ifdef DIV_ISSUE_DBZ_CNT_EN
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 100/7: two-cycle latency
    send(8'd100, 8'd7, '{q: 8'd14, r: 8'd2, dbz: 1'b0});
    chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
    chk("head_dividend", {24'd0, div_dividend}, 32'd100);
    chk("head_divisor", {24'd0, div_divisor}, 32'd7);
    @(posedge clk); #1;
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_q", {24'd0, out_quotient}, 32'd14);
    @(posedge clk); #1;
    chk("valid_drop", {31'd0, out_valid}, 32'd0);

    // 55/0: divide by zero
    send(8'd55, 8'd0, '{q: 8'hFF, r: 8'd55, dbz: 1'b1});
    @(posedge clk); #1;
    chk("dbz_flag", {31'd0, out_dbz}, 32'd1);
`ifdef DIV_ISSUE_DBZ_CNT_EN
    chk("err_count_1", {16'd0, err_count}, 32'd1);
`endif
    @(posedge clk); #1;

    // Backpressure: 5 accepted, 6th held, then burst out
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(ta[i], tb[i], model(ta[i], tb[i]));
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    in_valid    = 1'b1;
    in_dividend = 8'd77;
    in_divisor  = 8'd8;
    repeat (3) begin
      @(negedge clk);
      chk("held_in_ready", {31'd0, in_ready}, 32'd0);
      chk("held_out_q", {24'd0, out_quotient}, 32'd22);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    acc6 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("burst_valid", {31'd0, out_valid}, 32'd1);
      if (!acc6 && in_valid && in_ready) begin
        acc6 = 1;
        sb.push_back(model(8'd77, 8'd8));
      end
      @(posedge clk); #1;
      if (acc6) in_valid = 1'b0;
    end
    chk("sixth_accepted", {31'd0, acc6}, 32'd1);
    @(negedge clk);
    chk("burst_drained", sb.size(), 32'd0);
    chk("burst_idle", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Steady state at count=2 with push+pop every cycle; pointers wrap
    out_ready = 1'b0;
    send(8'd11, 8'd2, model(8'd11, 8'd2));
    send(8'd12, 8'd5, model(8'd12, 8'd5));
    send(8'd13, 8'd0, model(8'd13, 8'd0));
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = 8'(30 + i * 7);
      b = 8'(i % 3 + 2);
      in_valid    = 1'b1;
      in_dividend = a;
      in_divisor  = b;
      @(negedge clk);
      chk("steady_ready", {31'd0, in_ready}, 32'd1);
      if (in_ready) sb.push_back(model(a, b));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("steady_drained");

    // Asynchronous reset mid-burst
    out_ready = 1'b0;
    send(8'd40, 8'd3, model(8'd40, 8'd3));
    send(8'd41, 8'd4, model(8'd41, 8'd4));
    send(8'd42, 8'd5, model(8'd42, 8'd5));
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_div_dividend", {24'd0, div_dividend}, 32'd0);
    chk("async_out_q", {24'd0, out_quotient}, 32'd0);
    sb.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'd9, 8'd3, '{q: 8'd3, r: 8'd0, dbz: 1'b0});
    @(posedge clk); #1;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_q", {24'd0, out_quotient}, 32'd3);
    drain("post_rst_drained");

`ifdef DIV_ISSUE_DBZ_CNT_EN
    force dut.err_cnt_q = 16'hFFFE;
    #1 release dut.err_cnt_q;
    for (int i = 0; i < 3; i++) send(8'(i + 1), 8'd0, model(8'(i + 1), 8'd0));
    drain("sat_drained");
    @(posedge clk); #1;
    chk("err_count_sat", {16'd0, err_count}, 32'h0000FFFF);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("final_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
